// File: rtl/j_acc_deshifter_mc.sv
// Multi-lane serial-to-parallel deshifter that packs N_LANES serial streams into words and writes them to SRAM.
// Optional sticky drop flag on the overflow port: define J_DESHIFT_OVF_FLAG_EN.
module j_acc_deshifter_mc #(
  parameter int SRAM_DEPTH  = 262144,
  parameter int SRAM_ADDR_W = $clog2(SRAM_DEPTH),
  parameter int DATA_W      = 32,
  parameter int N_LANES     = 4,
  parameter int ADDR_STRIDE = N_LANES * DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        shift_start,
  input  logic [SRAM_ADDR_W-1:0]      start_addr,
  input  logic [SRAM_ADDR_W-1:0]      img_size,
  input  logic                        msb_first,
  input  logic [N_LANES-1:0]          serial_input,
  input  logic                        serial_en,
  output logic                        sram_en,
  input  logic                        sram_ready,
  output logic [SRAM_ADDR_W-1:0]      sram_addr,
  output logic [N_LANES*DATA_W-1:0]   sram_data,
  output logic                        shift_idle,
  output logic                        overflow
);

  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WORD_W = N_LANES * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN} state_t;

  state_t                  state;
  logic [BCNT_W-1:0]       bit_cnt;
  logic [SRAM_ADDR_W-1:0]  word_cnt;
  logic [SRAM_ADDR_W-1:0]  size_q;
  logic                    msb_q;
  logic [WORD_W-1:0]       lane_q;
  logic [WORD_W-1:0]       lane_nxt;
  logic                    shift_fire;
  logic                    word_done;
  logic                    accept;
  logic                    load;

  // LSB-first fills from the top so the first bit lands in bit 0; MSB-first fills from the bottom.
  function automatic logic [DATA_W-1:0] shift_lane(input logic [DATA_W-1:0] w,
                                                   input logic b, input logic msb);
    if (msb) return {w[DATA_W-2:0], b};
    else     return {b, w[DATA_W-1:1]};
  endfunction

  always_comb begin
    lane_nxt = lane_q;
    for (int k = 0; k < N_LANES; k++)
      lane_nxt[k*DATA_W +: DATA_W] = shift_lane(lane_q[k*DATA_W +: DATA_W], serial_input[k], msb_q);
  end

  assign shift_fire = (state == S_SHIFT) && serial_en;
  assign word_done  = shift_fire && (bit_cnt == BCNT_W'(DATA_W - 1));
  assign accept     = sram_en && sram_ready;
  // A completion may refill the buffer in the same cycle it is being accepted.
  assign load       = word_done && (!sram_en || accept);
  assign shift_idle = (state == S_IDLE);

  // Stage p0: lane shift registers (pure data, every bit overwritten before use)
  always_ff @(posedge clk) begin
    if (shift_fire) lane_q <= lane_nxt;
  end

  // Stage p1: control FSM and one-entry output buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      size_q    <= '0;
      msb_q     <= 1'b0;
      sram_en   <= 1'b0;
      sram_addr <= '0;
      sram_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (shift_start) begin
            state     <= S_SHIFT;
            sram_addr <= start_addr;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            size_q    <= img_size;
            msb_q     <= msb_first;
          end
        end
        S_SHIFT: begin
          if (serial_en) begin
            bit_cnt <= word_done ? '0 : bit_cnt + BCNT_W'(1);
            if (word_done) begin
              word_cnt <= word_cnt + SRAM_ADDR_W'(1);
              if (word_cnt == size_q) state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!sram_en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        sram_en   <= 1'b0;
        sram_addr <= sram_addr + SRAM_ADDR_W'(ADDR_STRIDE);
      end
      if (load) begin
        sram_en   <= 1'b1;
        sram_data <= lane_nxt;
      end
    end
  end

`ifdef J_DESHIFT_OVF_FLAG_EN
  logic ovf_q;

  // Stage p2: sticky record of any word lost to a full, unaccepted buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf_q <= 1'b0;
    else if ((state == S_IDLE) && shift_start)
      ovf_q <= 1'b0;
    else if (word_done && sram_en && !sram_ready)
      ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_j_acc_deshifter_mc.sv
// Randomized and directed bench for j_acc_deshifter_mc against a word-level reference model.
module tb_j_acc_deshifter_mc;

  localparam int AW     = 18;
  localparam int DW     = 32;
  localparam int NL     = 4;
  localparam int WW     = NL * DW;
  localparam int STRIDE = NL * DW / 8;

  logic          clk;
  logic          reset_n;
  logic          shift_start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] img_size;
  logic          msb_first;
  logic [NL-1:0] serial_input;
  logic          serial_en;
  logic          sram_en;
  logic          sram_ready;
  logic [AW-1:0] sram_addr;
  logic [WW-1:0] sram_data;
  logic          shift_idle;
  logic          overflow;

  j_acc_deshifter_mc dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .shift_start  (shift_start),
    .start_addr   (start_addr),
    .img_size     (img_size),
    .msb_first    (msb_first),
    .serial_input (serial_input),
    .serial_en    (serial_en),
    .sram_en      (sram_en),
    .sram_ready   (sram_ready),
    .sram_addr    (sram_addr),
    .sram_data    (sram_data),
    .shift_idle   (shift_idle),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: collects each lane's bits by arrival index, builds the word by plain indexing.
  int            m_phase;   // 0 idle, 1 collecting, 2 draining
  int            m_bcnt;
  int            m_words;
  int            m_size;
  bit            m_msb;
  bit            m_valid;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_data;
  bit            m_ovf;
  bit            bits [NL][DW];

  logic [AW-1:0] log_addr [$];
  logic [WW-1:0] log_data [$];

  task automatic model_clear();
    m_phase = 0; m_bcnt = 0; m_words = 0; m_size = 0; m_msb = 0;
    m_valid = 0; m_addr = '0; m_data = '0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit pre_valid;
    bit acc;
    bit done;
    logic [WW-1:0] w;
    pre_valid = m_valid;
    acc = m_valid && sram_ready;
    done = 0;
    w = '0;
    case (m_phase)
      0: if (shift_start) begin
        m_phase = 1; m_addr = start_addr; m_bcnt = 0; m_words = 0;
        m_size = int'(img_size); m_msb = msb_first; m_ovf = 0;
      end
      1: begin
        if (serial_en) begin
          for (int l = 0; l < NL; l++) bits[l][m_bcnt] = serial_input[l];
          m_bcnt++;
          if (m_bcnt == DW) begin
            m_bcnt = 0;
            done = 1;
            for (int l = 0; l < NL; l++)
              for (int i = 0; i < DW; i++)
                w[l*DW + (m_msb ? DW-1-i : i)] = bits[l][i];
          end
        end
        if (acc) begin m_addr = m_addr + AW'(STRIDE); m_valid = 0; end
        if (done) begin
          if (!pre_valid || acc) begin m_valid = 1; m_data = w; end
          else m_ovf = 1;
          if (m_words == m_size) m_phase = 2;
          m_words++;
        end
      end
      default: begin
        if (acc) begin m_addr = m_addr + AW'(STRIDE); m_valid = 0; end
        if (!pre_valid) m_phase = 0;
      end
    endcase
  endtask

  function automatic bit exp_ovf();
`ifdef J_DESHIFT_OVF_FLAG_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_all();
    check_val("sram_en", sram_en, m_valid);
    check_val("sram_addr", sram_addr, m_addr);
    check_val("sram_data", sram_data, m_data);
    check_val("shift_idle", shift_idle, m_phase == 0);
    check_val("overflow", overflow, exp_ovf());
  endtask

  // Called at a falling edge with inputs set; records DUT writes, advances one clock, compares.
  task automatic tick();
    if (sram_en && sram_ready) begin
      log_addr.push_back(sram_addr);
      log_data.push_back(sram_data);
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic b0, input logic sen, input logic rdy);
    serial_input    = NL'($urandom);
    serial_input[0] = b0;
    serial_en       = sen;
    sram_ready      = rdy;
    tick();
  endtask

  task automatic start_job(input logic [AW-1:0] a, input logic [AW-1:0] sz, input logic msb);
    shift_start = 1'b1; start_addr = a; img_size = sz; msb_first = msb;
    serial_en = 1'b0;
    tick();
    shift_start = 1'b0; start_addr = AW'($urandom); img_size = AW'($urandom); msb_first = 1'($urandom);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    serial_en = 1'b0;
    sram_ready = 1'b1;
    for (int c = 0; c < budget && !shift_idle; c++) tick();
    check_val(tag, shift_idle, 1'b1);
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1 model_clear();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [63:0]   pat;
  logic [WW-1:0] tmp;
  int            n0;

  initial begin
    reset_n = 1'b1; shift_start = 1'b0; start_addr = '0; img_size = '0; msb_first = 1'b0;
    serial_input = '0; serial_en = 1'b0; sram_ready = 1'b0;
    model_clear();
    #1 reset_n = 1'b0;
    #1 compare_all();
    @(negedge clk);
    reset_n = 1'b1;

    // LSB-first, two words, always ready
    pat = {32'h0BADF00D, 32'hDEADBEEF};
    n0 = log_addr.size();
    start_job(AW'('h100), AW'(1), 1'b0);
    for (int i = 0; i < 64; i++) drive(pat[i], 1'b1, 1'b1);
    wait_idle("lsb_idle", 20);
    check_val("lsb_nwr", log_addr.size() - n0, 2);
    if (log_addr.size() >= n0 + 2) begin
      check_val("lsb_a0", log_addr[n0], 'h100);
      check_val("lsb_a1", log_addr[n0+1], 'h110);
      tmp = log_data[n0];
      check_val("lsb_d0", tmp[31:0], 32'hDEADBEEF);
      tmp = log_data[n0+1];
      check_val("lsb_d1", tmp[31:0], 32'h0BADF00D);
    end

    // MSB-first gives the bit-reversed word
    n0 = log_addr.size();
    start_job(AW'('h200), AW'(1), 1'b1);
    for (int i = 0; i < 64; i++) drive(pat[i % 32], 1'b1, 1'b1);
    wait_idle("msb_idle", 20);
    check_val("msb_nwr", log_addr.size() - n0, 2);
    if (log_addr.size() >= n0 + 1) begin
      tmp = log_data[n0];
      check_val("msb_d0", tmp[31:0], 32'hF77DB57B);
    end

    // SRAM stalls across both completions: first word held, second dropped
    n0 = log_addr.size();
    start_job(AW'('h300), AW'(1), 1'b0);
    for (int i = 0; i < 64; i++) drive(pat[i], 1'b1, i < 24);
    check_val("stall_busy", shift_idle, 1'b0);
    check_val("stall_en", sram_en, 1'b1);
    check_val("stall_addr", sram_addr, 'h300);
`ifdef J_DESHIFT_OVF_FLAG_EN
    check_val("stall_ovf", overflow, 1'b1);
`else
    check_val("stall_ovf", overflow, 1'b0);
`endif
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);
    wait_idle("stall_idle", 20);
    check_val("stall_nwr", log_addr.size() - n0, 1);
    if (log_addr.size() >= n0 + 1) begin
      tmp = log_data[n0];
      check_val("stall_d0", tmp[31:0], 32'hDEADBEEF);
    end

    // Acceptance coincides with the next completion: no drop
    n0 = log_addr.size();
    start_job(AW'('h400), AW'(1), 1'b0);
    for (int i = 0; i < 64; i++) drive(pat[i], 1'b1, i == 63);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
    check_val("coin_ovf", overflow, 1'b0);
    wait_idle("coin_idle", 20);
    check_val("coin_nwr", log_addr.size() - n0, 2);
    if (log_addr.size() >= n0 + 2) begin
      check_val("coin_a0", log_addr[n0], 'h400);
      check_val("coin_a1", log_addr[n0+1], 'h410);
      tmp = log_data[n0+1];
      check_val("coin_d1", tmp[31:0], 32'h0BADF00D);
    end

    // Address wraps at the top of the address space
    n0 = log_addr.size();
    start_job(AW'((1 << AW) - 16), AW'(1), 1'b0);
    for (int i = 0; i < 64; i++) drive(pat[i], 1'b1, 1'b1);
    wait_idle("wrap_idle", 20);
    check_val("wrap_nwr", log_addr.size() - n0, 2);
    if (log_addr.size() >= n0 + 2) check_val("wrap_a1", log_addr[n0+1], 0);

    // Reset mid-word abandons the job; serial_en alone does not restart it
    start_job(AW'('h500), AW'(3), 1'b0);
    for (int i = 0; i < 10; i++) drive(1'($urandom), 1'b1, 1'b1);
    apply_reset();
    n0 = log_addr.size();
    for (int i = 0; i < 40; i++) drive(1'($urandom), 1'($urandom), 1'($urandom));
    check_val("rst_nwr", log_addr.size() - n0, 0);
    check_val("rst_idle", shift_idle, 1'b1);

    // Randomized jobs with random gaps, stalls and ignored start pulses
    for (int j = 0; j < 8; j++) begin
      start_job(AW'($urandom), AW'($urandom_range(0, 3)), 1'($urandom));
      for (int c = 0; c < 3000 && !shift_idle; c++) begin
        shift_start = ($urandom_range(0, 15) == 0);
        drive(1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
      end
      shift_start = 1'b0;
      check_val("rand_done", shift_idle, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/j_acc_deshifter_mc.md
J_ACC_DESHIFTER_MC -- requirements
Module: j_acc_deshifter_mc

Interface
REQ-001 SHALL have parameter SRAM_DEPTH, default 262144, SRAM word-address space size.
REQ-002 SHALL have parameter SRAM_ADDR_W, default clog2(SRAM_DEPTH), address width.
REQ-003 SHALL have parameter DATA_W, default 32, bits per lane word (legal 8..64).
REQ-004 SHALL have parameter N_LANES, default 4, number of parallel serial lanes (legal 1..16).
REQ-005 SHALL have parameter ADDR_STRIDE, default N_LANES*DATA_W/8, address increment per accepted write.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port shift_start  input  1  start request, honoured only in S_IDLE.
REQ-009 SHALL have port start_addr  input  SRAM_ADDR_W  first write address, sampled with accepted shift_start.
REQ-010 SHALL have port img_size  input  SRAM_ADDR_W  number of words per job minus one, sampled with accepted shift_start.
REQ-011 SHALL have port msb_first  input  1  0 = LSB-first bit order, 1 = MSB-first; sampled with accepted shift_start.
REQ-012 SHALL have port serial_input  input  N_LANES  one serial bit per lane.
REQ-013 SHALL have port serial_en  input  1  qualifies serial_input for the current cycle.
REQ-014 SHALL have port sram_en  output  1  write request, high while output buffer is full.
REQ-015 SHALL have port sram_ready  input  1  SRAM accepts write when sram_en & sram_ready.
REQ-016 SHALL have port sram_addr  output  SRAM_ADDR_W  address of buffered word.
REQ-017 SHALL have port sram_data  output  N_LANES*DATA_W  buffered word; lane k in bits [k*DATA_W +: DATA_W].
REQ-018 SHALL have port shift_idle  output  1  high when FSM is in S_IDLE.
REQ-019 SHALL have port overflow  output  1  sticky drop flag (see Configuration).

Function
REQ-020 SHALL implement FSM S_IDLE, S_SHIFT, S_DRAIN; S_IDLE->S_SHIFT on shift_start; S_SHIFT->S_DRAIN on completion of word number img_size; S_DRAIN->S_IDLE on the cycle the buffer is empty.
REQ-021 SHALL on accepted shift_start load write address start_addr and clear bit counter, word counter and overflow.
REQ-022 SHALL ignore serial_en outside S_SHIFT (no shift, no count).
REQ-023 SHALL in S_SHIFT with serial_en shift every lane register: LSB-first inserts bit at MSB and shifts right; MSB-first inserts at LSB and shifts left.
REQ-024 SHALL count serial_en cycles modulo DATA_W; the cycle with count DATA_W-1 completes a word.
REQ-025 SHALL load the completed word (all lanes, including the completing bit) into the one-entry output buffer at that edge; sram_en high the following cycle.
REQ-026 SHALL hold sram_en, sram_addr, sram_data stable until sram_en & sram_ready; on acceptance increment write address by ADDR_STRIDE modulo 2^SRAM_ADDR_W.
REQ-027 SHALL, when acceptance and a new completion coincide, load the new word without drop.
REQ-028 SHALL, when a word completes while the buffer is full and not accepted, drop the new word, still advance the word counter, and not advance the address.
REQ-029 SHALL ignore shift_start in S_SHIFT and S_DRAIN.

Reset
REQ-030 SHALL on reset_n low, asynchronously: FSM S_IDLE, sram_en 0, sram_addr 0, sram_data 0, all counters 0, overflow 0; shift_idle 1.
REQ-031 SHALL abandon any in-progress job on reset; no write issues after release until a new shift_start.

Configuration
REQ-032 SHALL, with macro J_DESHIFT_OVF_FLAG_EN defined, set overflow on any drop per REQ-028, holding until reset or accepted shift_start.
REQ-033 SHALL, without J_DESHIFT_OVF_FLAG_EN, tie overflow to 0; drop behaviour per REQ-028 unchanged.

Verification
REQ-034 SHALL cover: defaults, sram_ready=1, start_addr=0x100, img_size=1, LSB-first, 64 serial_en cycles with lane0 pattern 0xDEADBEEF -> two writes at 0x100 and 0x110, lane0 bits [31:0]=0xDEADBEEF, then shift_idle=1.
REQ-035 SHALL cover: same stream with msb_first=1 -> lane0 word bit-reversed, 0xF77DB57B.
REQ-036 SHALL cover: sram_ready=0 for 40 cycles across two completions -> one write held stable, second word dropped, overflow=1 (macro on) / 0 (macro off), FSM reaches S_DRAIN then S_IDLE after acceptance.
REQ-037 SHALL cover: sram_ready pulses exactly on next completion edge -> no drop, consecutive addresses, overflow=0.
REQ-038 SHALL cover: start_addr=2^SRAM_ADDR_W-16, img_size=1 -> second write at address 0 (wrap).
REQ-039 SHALL cover: reset_n low mid-word, then serial_en toggling without shift_start -> all outputs at reset values, no sram_en.
